vga_frame_reader: RTL and testbench

// - Read-side counterpart of the camera-to-SDRAM write path.
// - Generates 640x480@60 VGA timing on the 25 MHz pixel clock and pops both SDRAM read FIFOs in lockstep.
// - Unpacks the two 16-bit words {1'b0,G[9:5],B[9:0]} and {1'b0,G[4:0],R[9:0]} into 10-bit RGB.
// - Drives the VGA pins with the 8 MSBs per colour.

---
 rtl/vga_frame_reader_if.sv | 21 ++
 rtl/vga_frame_reader.sv | 181 ++++++++++++++++++
 tb/tb_vga_frame_reader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_frame_reader_if.sv
// Read-FIFO side of the VGA frame reader: pop request plus the two paired data words and empty flag.
interface vga_frame_reader_if;
  logic        o_rd_req;
  logic [15:0] i_rd_data1;
  logic [15:0] i_rd_data2;
  logic        i_rd_empty;

  modport master (
    output o_rd_req,
    input  i_rd_data1,
    input  i_rd_data2,
    input  i_rd_empty
  );

  modport slave (
    input  o_rd_req,
    output i_rd_data1,
    output i_rd_data2,
    output i_rd_empty
  );
endinterface

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA timing generator that pops two SDRAM read FIFOs in lockstep and unpacks 10-bit RGB.
// Optional colour-bar generator enabled by defining TEST_PATTERN_EN (adds i_pattern).
module vga_frame_reader #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  vga_frame_reader_if.master         rd,
  input  logic                       i_clr_underflow,
`ifdef TEST_PATTERN_EN
  input  logic                       i_pattern,
`endif
  output logic                       o_frame_start,
  output logic                       o_underflow,
  output logic [7:0]                 o_VGA_R,
  output logic [7:0]                 o_VGA_G,
  output logic [7:0]                 o_VGA_B,
  output logic                       o_H_sync,
  output logic                       o_V_sync,
  output logic                       o_VGA_BLANK_N
);

  localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(H_TOT);
  localparam int unsigned VW     = $clog2(V_TOT);
  localparam int unsigned BAR_W  = H_ACTIVE / 8;

  // Stage 0: raster counters
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  // Stage 1
  logic       req_q, emp1_q, fs_q;
  logic       hs1_q, vs1_q, bl1_q, pat1_q;
  logic [2:0] bar1_q;

  // Stage 2
  logic       emp2_q;
  logic       hs2_q, vs2_q, bl2_q, pat2_q;
  logic [2:0] bar2_q;

  // Stage 3 (pins)
  logic [7:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic       hs3_q, vs3_q, bl3_q;
  logic       und_q;

  logic       active0, hs0, vs0, fs0, pat0;
  logic [2:0] bar0;

`ifdef TEST_PATTERN_EN
  assign pat0 = i_pattern;
`else
  assign pat0 = 1'b0;
`endif

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == HW'(H_TOT - 1)) begin
      h_d = '0;
      v_d = (v_q == VW'(V_TOT - 1)) ? '0 : v_q + 1'b1;
    end
  end

  always_comb begin
    active0 = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    hs0     = !((h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
    vs0     = !((v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
    fs0     = (h_q == '0) && (v_q == VW'(V_ACTIVE));
  end

  always_comb begin
    bar0 = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (h_q >= HW'(i * BAR_W)) bar0 = 3'(i);
    end
  end

  // FIFO words arrive the cycle after the pop; bit 15 of each is padding
  logic [9:0] unp_r, unp_g, unp_b;
  logic       unused_bits;

  assign unp_r       = rd.i_rd_data2[9:0];
  assign unp_g       = {rd.i_rd_data1[14:10], rd.i_rd_data2[14:10]};
  assign unp_b       = rd.i_rd_data1[9:0];
  assign unused_bits = ^{rd.i_rd_data1[15], rd.i_rd_data2[15],
                         unp_r[1:0], unp_g[1:0], unp_b[1:0]};

  // Bar order white,yellow,cyan,green,magenta,red,blue,black reduces to per-bit inversion of the index
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (bl2_q) begin
      if (pat2_q) begin
        r_d = {8{~bar2_q[1]}};
        g_d = {8{~bar2_q[2]}};
        b_d = {8{~bar2_q[0]}};
      end else if (!emp2_q) begin
        r_d = unp_r[9:2];
        g_d = unp_g[9:2];
        b_d = unp_b[9:2];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_q    <= '0;
      v_q    <= '0;
      req_q  <= 1'b0;
      emp1_q <= 1'b0;
      fs_q   <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      bl1_q  <= 1'b0;
      pat1_q <= 1'b0;
      bar1_q <= '0;
      emp2_q <= 1'b0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      bl2_q  <= 1'b0;
      pat2_q <= 1'b0;
      bar2_q <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hs3_q  <= 1'b1;
      vs3_q  <= 1'b1;
      bl3_q  <= 1'b0;
      und_q  <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      req_q  <= active0 && !pat0;
      emp1_q <= active0 && !pat0 && rd.i_rd_empty;
      fs_q   <= fs0;
      hs1_q  <= hs0;
      vs1_q  <= vs0;
      bl1_q  <= active0;
      pat1_q <= pat0;
      bar1_q <= bar0;
      emp2_q <= emp1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      bl2_q  <= bl1_q;
      pat2_q <= pat1_q;
      bar2_q <= bar1_q;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      hs3_q  <= hs2_q;
      vs3_q  <= vs2_q;
      bl3_q  <= bl2_q;
      if (emp1_q) begin
        und_q <= 1'b1;
      end else if (i_clr_underflow) begin
        und_q <= 1'b0;
      end
    end
  end

  assign rd.o_rd_req   = req_q;
  assign o_frame_start = fs_q;
  assign o_underflow   = und_q;
  assign o_VGA_R       = r_q;
  assign o_VGA_G       = g_q;
  assign o_VGA_B       = b_q;
  assign o_H_sync      = hs3_q;
  assign o_V_sync      = vs3_q;
  assign o_VGA_BLANK_N = bl3_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader, run with a shortened vertical raster so whole frames fit.
module tb_vga_frame_reader;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 6,   VF = 2,  VS = 2,  VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        bl;
    logic        pat;
    logic [23:0] prgb;
  } pst_t;

  localparam pst_t PRST = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, pat: 1'b0, prgb: 24'h0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       pattern = 1'b0;
  logic       o_frame_start, o_underflow, o_H_sync, o_V_sync, o_VGA_BLANK_N;
  logic [7:0] o_VGA_R, o_VGA_G, o_VGA_B;

  vga_frame_reader_if rd_if();

  vga_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .rd              (rd_if),
    .i_clr_underflow (clr),
`ifdef TEST_PATTERN_EN
    .i_pattern       (pattern),
`endif
    .o_frame_start   (o_frame_start),
    .o_underflow     (o_underflow),
    .o_VGA_R         (o_VGA_R),
    .o_VGA_G         (o_VGA_G),
    .o_VGA_B         (o_VGA_B),
    .o_H_sync        (o_H_sync),
    .o_V_sync        (o_V_sync),
    .o_VGA_BLANK_N   (o_VGA_BLANK_N)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [23:0] patcol(input int h);
    case (h / 80)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic pst_t stage0(input int h, input int v, input logic pat);
    pst_t s;
    s.hs   = !(h >= HA + HF && h < HA + HF + HS);
    s.vs   = !(v >= VA + VF && v < VA + VF + VS);
    s.bl   = (h < HA) && (v < VA);
    s.pat  = pat;
    s.prgb = patcol(h);
    return s;
  endfunction

  function automatic logic [23:0] unpack(input logic [15:0] d1, input logic [15:0] d2);
    logic [9:0] r, g, b;
    r = d2[9:0];
    g = {d1[14:10], d2[14:10]};
    b = d1[9:0];
    return {r[9:2], g[9:2], b[9:2]};
  endfunction

  // Reference model state, advanced once per cycle at the falling edge
  int          mh = 0, mv = 0, cyc = 0;
  pst_t        p1 = PRST, p2 = PRST, p3 = PRST;
  logic        ereq = 0, efs = 0, eund = 0, memp1 = 0;
  logic        prev_rst = 1, prev_empty = 0, prev_clr = 0, prev_pat = 0;
  logic        pend_req = 0, pend_emp = 0, dir_en = 0, pat_win = 0;
  logic [23:0] sbq[$];
  int          hs_low = 0, vs_low = 0, bl_hi = 0, req_n = 0, fs_n = 0;
  int          line_req = 0, first_req = -1, pat_req = 0;

  always @(negedge clk) begin : model
    logic [23:0] exp_rgb;
    logic        act;
    if (prev_rst) begin
      mh = 0; mv = 0; cyc = 0;
      p1 = PRST; p2 = PRST; p3 = PRST;
      ereq = 0; efs = 0; eund = 0; memp1 = 0;
      sbq.delete();
      hs_low = 0; vs_low = 0; bl_hi = 0; req_n = 0; fs_n = 0;
      line_req = 0; first_req = -1;
    end else begin
      act   = (mh < HA) && (mv < VA);
      eund  = memp1 ? 1'b1 : (prev_clr ? 1'b0 : eund);
      p3    = p2;
      p2    = p1;
      p1    = stage0(mh, mv, prev_pat);
      ereq  = act && !prev_pat;
      memp1 = act && !prev_pat && prev_empty;
      efs   = (mh == 0) && (mv == VA);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      cyc++;
    end

    check("ctl", {26'd0, rd_if.o_rd_req, o_frame_start, o_underflow, o_H_sync, o_V_sync, o_VGA_BLANK_N},
                 {26'd0, ereq, efs, eund, p3.hs, p3.vs, p3.bl});
    exp_rgb = 24'h0;
    if (p3.bl) begin
      if (p3.pat) begin
        exp_rgb = p3.prgb;
      end else begin
        check("sb_level", {31'd0, sbq.size() > 0}, 32'd1);
        if (sbq.size() > 0) exp_rgb = sbq.pop_front();
      end
    end
    check("rgb", {8'd0, o_VGA_R, o_VGA_G, o_VGA_B}, {8'd0, exp_rgb});

    if (cyc < 2 * FRAME) begin
      if (!o_H_sync)      hs_low++;
      if (!o_V_sync)      vs_low++;
      if (o_VGA_BLANK_N)  bl_hi++;
      if (rd_if.o_rd_req) req_n++;
      if (o_frame_start)  fs_n++;
    end
    if (cyc < HT && rd_if.o_rd_req) line_req++;
    if (rd_if.o_rd_req && first_req < 0) first_req = cyc;
    if (pat_win && rd_if.o_rd_req) pat_req++;

    pend_req   = ereq;
    pend_emp   = memp1;
    prev_rst   = rst;
    prev_empty = rd_if.i_rd_empty;
    prev_clr   = clr;
    prev_pat   = pattern;
  end

  // FIFO model: answers each pop with a fresh word pair and queues the pixel it should become
  initial begin : fifo
    logic [15:0] d1, d2;
    rd_if.i_rd_data1 = '0;
    rd_if.i_rd_data2 = '0;
    forever begin
      @(posedge clk);
      #2;
      if (pend_req) begin
        d1 = 16'($urandom);
        d2 = 16'($urandom);
        if (dir_en) begin
          d1 = 16'h7EAB;
          d2 = 16'h7D55;
        end
        rd_if.i_rd_data1 = d1;
        rd_if.i_rd_data2 = d2;
        if (pend_emp)    sbq.push_back(24'h0);
        else if (dir_en) sbq.push_back(24'h55FFAA);
        else             sbq.push_back(unpack(d1, d2));
      end
    end
  end

  // Returns one step after the model counter shows (h,v): the current cycle holds the next position
  task automatic wait_prev(input int h, input int v);
    bit hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = (mh == h) && (mv == v);
    end
    if (!hit) check("wait_pos", {31'd0, hit}, 32'd1);
  endtask

  task automatic wait_cyc(input int n);
    bit hit = 0;
    for (int i = 0; i < 3 * FRAME && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = (cyc >= n);
    end
    if (!hit) check("wait_cyc", {31'd0, hit}, 32'd1);
  endtask

  initial begin : stim
    rd_if.i_rd_empty = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;

    wait_prev(99, 1);
    rd_if.i_rd_empty = 1'b1;
    @(posedge clk); #1 rd_if.i_rd_empty = 1'b0;
    wait_prev(150, 1);
    check("und_set", {31'd0, o_underflow}, 32'd1);
    wait_prev(199, 1);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    wait_prev(250, 1);
    check("und_clr", {31'd0, o_underflow}, 32'd0);

    wait_prev(HT - 1, 1);
    dir_en = 1'b1;
    wait_prev(HT - 1, 2);
    dir_en = 1'b0;

    // empty and clear land on the same underflow update: set must win
    wait_prev(299, 3);
    rd_if.i_rd_empty = 1'b1;
    @(posedge clk); #1 rd_if.i_rd_empty = 1'b0; clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    wait_prev(400, 3);
    check("und_set_wins", {31'd0, o_underflow}, 32'd1);

    wait_cyc(2 * FRAME);
    check("hsync_low", 32'(hs_low), 32'(2 * VT * HS));
    check("vsync_low", 32'(vs_low), 32'(2 * VS * HT));
    check("blank_hi",  32'(bl_hi),  32'(2 * VA * HA));
    check("req_cnt",   32'(req_n),  32'(2 * VA * HA));
    check("fs_cnt",    32'(fs_n),   32'd2);

    wait_prev(299, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_blank", {31'd0, o_VGA_BLANK_N}, 32'd0);
    check("rst_req",   {31'd0, rd_if.o_rd_req}, 32'd0);
    check("rst_sync",  {30'd0, o_H_sync, o_V_sync}, 32'd3);
    check("rst_und",   {31'd0, o_underflow}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wait_cyc(HT + 2);
    check("first_req", 32'(first_req), 32'd1);
    check("line_req",  32'(line_req),  32'(HA));

`ifdef TEST_PATTERN_EN
    wait_prev(HT - 1, VT - 1);
    pattern = 1'b1;
    pat_win = 1'b1;
    wait_prev(HT - 1, VT - 1);
    pattern = 1'b0;
    pat_win = 1'b0;
    check("pat_req", 32'(pat_req), 32'd0);
`endif

    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
